acc_norm_seq: RTL and testbench
===============================

Name: acc_norm_seq

Overview:
- Sequencer for one K-term dot-product accumulation followed by the fraction/scale-factor normalisation stage.
- Accepts K operand-pair beats over a valid/ready handshake and issues the multiplier/accumulator strobes: clear, enable and the vld_d valid pipe.
- Waits out the accumulator latency, then holds acc_rdy for the normalisation latency. It then presents out_vld to the consumer with backpressure.
- Sits between the operand feeder and the MAC-accumulator plus normalisation datapath.

Parameters:
- K, 9, number of terms per dot product (>=1).
- ACC_LAT, 4, cycles from acc_en to the accumulator chunks being stable (>=1).
- NORM_LAT, 3, cycles acc_rdy must stay high for sign_q/sf_q/mts_q to settle (>=1).
- VLD_W, 12, width of the vld_d valid pipe. Must satisfy ACC_LAT+NORM_LAT+1 <= VLD_W; elaboration error otherwise.
- CNT_W, $clog2(K+1), term counter width.

Ports:
- clk_i, in, 1, clock.
- rst, in, 1, reset; synchronous, active-high.
- in_vld, in, 1, operand pair valid.
- in_rdy, out, 1, sequencer can take an operand pair.
- acc_clr, out, 1, accumulator clear, coincident with the first term's acc_en.
- acc_en, out, 1, accumulate the term fired in the previous cycle.
- vld_d, out, VLD_W, valid pipe into the datapath; nonzero while a job is in flight.
- acc_rdy, out, 1, accumulator result stable; normalisation stage may sample.
- out_vld, out, 1, sign/ovf/udf/nzero/sf_q/mts_q valid.
- out_rdy, in, 1, consumer accepts the result.
- term_cnt, out, CNT_W, terms accepted in the current job.
- busy, out, 1, state != IDLE.

Behaviour:
- Reset values: every output 0 (in_rdy is combinational, so it reads 1 after reset). State IDLE, counters 0. Reset mid-job abandons the job; nothing partial is emitted.
- fire = in_vld & in_rdy.
- in_rdy = (state==IDLE) | (state==ACCUM). in_rdy is combinational; all other outputs are registered.
- IDLE: on fire, go to ACCUM, term_cnt<=1, acc_clr<=1, acc_en<=1. If K==1, go directly to DRAIN instead.
- ACCUM: each fire does acc_en<=1 next cycle and term_cnt+1. acc_clr is 0 except for the first term.
- ACCUM: fire when term_cnt==K-1 moves to DRAIN with lat_cnt<=0. No fire means acc_en<=0; gaps are allowed.
- DRAIN: in_rdy=0; in_vld is ignored, not lost. Lasts ACC_LAT cycles, then go to NORM.
- NORM: acc_rdy=1 on every NORM cycle, NORM_LAT cycles total, accumulator frozen (acc_en=0). Then go to HOLD with out_vld<=1.
- HOLD: acc_rdy=0; out_vld held until out_rdy. On out_vld&out_rdy: out_vld<=0, term_cnt<=0, state IDLE.
- out_rdy already high when out_vld rises gives a single-cycle out_vld. A new job can fire the cycle after return to IDLE.
- Timing: last fire at cycle L gives acc_en at L+1, acc_rdy on cycles L+1+ACC_LAT .. L+ACC_LAT+NORM_LAT, and out_vld from L+1+ACC_LAT+NORM_LAT.
- vld_d <= {vld_d[VLD_W-2:0], fire | (state inside {DRAIN,NORM,HOLD})}. This keeps vld_d nonzero through the whole job so the datapath does not self-clear.
- vld_d returns to 0 exactly VLD_W cycles after the last active bit once idle.
- out_rdy outside HOLD is ignored.

Optional Feature:
- Macro ACC_NORM_SEQ_ABORT_EN.
- With the macro: extra input port abort (1 bit). abort=1 in any non-IDLE state gives, next cycle, state IDLE and term_cnt, acc_en, acc_clr, acc_rdy and out_vld all 0.
- abort also zero-fills the vld_d feed bit so the datapath self-clears.
- abort has priority over fire, and over out_rdy in the same cycle. abort in IDLE is a no-op, and fire is still honoured that cycle.
- Without the macro: no abort port; the only way to cancel a job is rst.

Decomposition:
- Shared package acc_norm_pkg holds:
  - state enum: IDLE, ACCUM, DRAIN, NORM, HOLD;
  - default latency constants ACC_LAT_DEF=4, NORM_LAT_DEF=3, VLD_W_DEF=12;
  - the latency-legality check function.
- One sub-module: lat_timer, a loadable down-counter with a done pulse, shared by DRAIN and NORM.

Test Plan:
- K=9, in_vld high cycles 1-9, out_rdy=1 -> acc_clr only at cycle 2, acc_en 2-10, in_rdy low 10-17, acc_rdy 14-16, out_vld only at 17, busy low at 18.
- Same job with in_vld gaps at cycles 3 and 6 (last fire at 11) -> acc_en 2-12 minus 4 and 7, acc_rdy 16-18, out_vld 19.
- out_rdy held low 10 cycles after out_vld rises -> out_vld stable, acc_rdy 0, vld_d nonzero throughout. Return to IDLE the cycle after out_rdy.
- K=1, single fire at cycle 1 -> acc_clr and acc_en at 2, acc_rdy 6-8, out_vld 9.
- rst asserted at cycle 12 mid-DRAIN -> cycle 13 all outputs 0, state IDLE. vld_d 0 thereafter, next job behaves as the first scenario.
- With ACC_NORM_SEQ_ABORT_EN: abort at cycle 15 with in_vld=1 -> cycle 16 IDLE, acc_rdy 0, no out_vld. fire accepted at cycle 16.

Source files
------------

// File: rtl/acc_norm_pkg.sv
// Shared types and latency constants for the dot-product accumulate/normalise sequencer.
package acc_norm_pkg;

  typedef enum logic [2:0] {IDLE, ACCUM, DRAIN, NORM, HOLD} state_e;

  localparam int ACC_LAT_DEF  = 4;
  localparam int NORM_LAT_DEF = 3;
  localparam int VLD_W_DEF    = 12;

  // The valid pipe must cover the full drain+normalise window plus the last term.
  function automatic bit lat_legal(input int acc_lat, input int norm_lat, input int vld_w);
    return (acc_lat >= 1) && (norm_lat >= 1) && (acc_lat + norm_lat + 1 <= vld_w);
  endfunction

endpackage

// File: rtl/acc_norm_seq_lat_timer.sv
// Loadable down-counter; done is high on the last cycle of a loaded interval while enabled.
module lat_timer #(
  parameter int W = 3
) (
  input  logic         clk_i,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk_i) begin
    if (rst)                    cnt <= '0;
    else if (load)              cnt <= load_val;
    else if (en && cnt != '0)   cnt <= cnt - W'(1);
  end

  assign done = en & (cnt == '0);

endmodule

// File: rtl/acc_norm_seq.sv
// K-term accumulate then normalise sequencer with valid/ready in and backpressured result.
// Optional abort input enabled by defining ACC_NORM_SEQ_ABORT_EN.
module acc_norm_seq
  import acc_norm_pkg::*;
#(
  parameter int K        = 9,
  parameter int ACC_LAT  = ACC_LAT_DEF,
  parameter int NORM_LAT = NORM_LAT_DEF,
  parameter int VLD_W    = VLD_W_DEF,
  parameter int CNT_W    = $clog2(K + 1)
) (
  input  logic             clk_i,
  input  logic             rst,
  input  logic             in_vld,
  output logic             in_rdy,
  output logic             acc_clr,
  output logic             acc_en,
  output logic [VLD_W-1:0] vld_d,
  output logic             acc_rdy,
  output logic             out_vld,
  input  logic             out_rdy,
`ifdef ACC_NORM_SEQ_ABORT_EN
  input  logic             abort,
`endif
  output logic [CNT_W-1:0] term_cnt,
  output logic             busy
);

  localparam int LAT_MAX = (ACC_LAT > NORM_LAT) ? ACC_LAT : NORM_LAT;
  localparam int LAT_W   = $clog2(LAT_MAX + 1);

  if (!lat_legal(ACC_LAT, NORM_LAT, VLD_W) || K < 1) begin : g_bad_cfg
    $error("acc_norm_seq: illegal K/ACC_LAT/NORM_LAT/VLD_W combination");
  end

  state_e     state;
  logic       fire, kill, last, feed;
  logic       t_load, t_en, t_done;
  logic [LAT_W-1:0] t_val;

`ifdef ACC_NORM_SEQ_ABORT_EN
  assign kill = abort & (state != IDLE);
`else
  assign kill = 1'b0;
`endif

  assign in_rdy = (state == IDLE) | (state == ACCUM);
  assign fire   = in_vld & in_rdy;
  assign busy   = (state != IDLE);
  // term_cnt is 0 in IDLE, so only the K==1 case can finish on the first beat
  assign last   = (K == 1) || (term_cnt == CNT_W'(K - 1));
  assign feed   = ~kill & (fire | (state inside {DRAIN, NORM, HOLD}));

  assign t_en   = (state == DRAIN) | (state == NORM);
  assign t_load = (fire & ~kill & last) | ((state == DRAIN) & t_done & ~kill);
  assign t_val  = (state == DRAIN) ? LAT_W'(NORM_LAT - 1) : LAT_W'(ACC_LAT - 1);

  lat_timer #(.W(LAT_W)) u_timer (
    .clk_i    (clk_i),
    .rst      (rst),
    .load     (t_load),
    .load_val (t_val),
    .en       (t_en),
    .done     (t_done)
  );

  always_ff @(posedge clk_i) begin
    if (rst) begin
      state    <= IDLE;
      term_cnt <= '0;
      acc_clr  <= 1'b0;
      acc_en   <= 1'b0;
      acc_rdy  <= 1'b0;
      out_vld  <= 1'b0;
      vld_d    <= '0;
    end else begin
      acc_clr <= 1'b0;
      acc_en  <= 1'b0;
      acc_rdy <= 1'b0;
      vld_d   <= {vld_d[VLD_W-2:0], feed};
      if (kill) begin
        state    <= IDLE;
        term_cnt <= '0;
        out_vld  <= 1'b0;
      end else begin
        case (state)
          IDLE, ACCUM: if (fire) begin
            acc_en   <= 1'b1;
            acc_clr  <= (state == IDLE);
            term_cnt <= term_cnt + CNT_W'(1);
            state    <= last ? DRAIN : ACCUM;
          end
          DRAIN: if (t_done) begin
            state   <= NORM;
            acc_rdy <= 1'b1;
          end
          NORM: if (t_done) begin
            state   <= HOLD;
            out_vld <= 1'b1;
          end else begin
            acc_rdy <= 1'b1;
          end
          HOLD: if (out_rdy) begin
            out_vld  <= 1'b0;
            term_cnt <= '0;
            state    <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_acc_norm_seq.sv
// Directed bench for acc_norm_seq: K=9 main instance plus a K=1 instance.
module tb_acc_norm_seq;

  logic clk_i = 1'b0;
  logic rst;
  logic in_vld, out_rdy, in_vld1, out_rdy1;
`ifdef ACC_NORM_SEQ_ABORT_EN
  logic abort;
`endif

  logic        in_rdy, acc_clr, acc_en, acc_rdy, out_vld, busy;
  logic [11:0] vld_d;
  logic [3:0]  term_cnt;
  logic        in_rdy1, acc_clr1, acc_en1, acc_rdy1, out_vld1, busy1;
  logic [11:0] vld_d1;
  logic [0:0]  term_cnt1;

  int vecs = 0;
  int errs = 0;

  // term_cnt per cycle for the gapped job (fires at 1,2,4,5,7..11)
  int tc_gap [22] = '{0,1,2,2,3,4,4,5,6,7,8,9,9,9,9,9,9,9,9,0,0,0};

  always #5 clk_i = ~clk_i;

  acc_norm_seq dut (
    .clk_i(clk_i), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy),
    .acc_clr(acc_clr), .acc_en(acc_en), .vld_d(vld_d), .acc_rdy(acc_rdy),
    .out_vld(out_vld), .out_rdy(out_rdy),
`ifdef ACC_NORM_SEQ_ABORT_EN
    .abort(abort),
`endif
    .term_cnt(term_cnt), .busy(busy)
  );

  acc_norm_seq #(.K(1)) dut1 (
    .clk_i(clk_i), .rst(rst), .in_vld(in_vld1), .in_rdy(in_rdy1),
    .acc_clr(acc_clr1), .acc_en(acc_en1), .vld_d(vld_d1), .acc_rdy(acc_rdy1),
    .out_vld(out_vld1), .out_rdy(out_rdy1),
`ifdef ACC_NORM_SEQ_ABORT_EN
    .abort(1'b0),
`endif
    .term_cnt(term_cnt1), .busy(busy1)
  );

  task automatic step;
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; in_vld = 1'b0; out_rdy = 1'b0; in_vld1 = 1'b0; out_rdy1 = 1'b0;
`ifdef ACC_NORM_SEQ_ABORT_EN
    abort = 1'b0;
`endif
    repeat (2) step();
    rst = 1'b0;
  endtask

  // {in_rdy, acc_clr, acc_en, acc_rdy, out_vld, busy}
  function automatic logic [5:0] exp_basic(input int c);
    return {!(c >= 10 && c <= 17), c == 2, (c >= 2 && c <= 10),
            (c >= 14 && c <= 16), c == 17, (c >= 2 && c <= 17)};
  endfunction

  function automatic logic [3:0] tc_basic(input int c);
    if (c >= 2 && c <= 10) return 4'(c - 1);
    if (c >= 11 && c <= 17) return 4'd9;
    return 4'd0;
  endfunction

  task automatic test_reset;
    rst = 1'b1; in_vld = 1'b0; out_rdy = 1'b0; in_vld1 = 1'b0; out_rdy1 = 1'b0;
`ifdef ACC_NORM_SEQ_ABORT_EN
    abort = 1'b0;
`endif
    repeat (2) step();
    vecs++;
    if ({in_rdy, acc_clr, acc_en, acc_rdy, out_vld, busy, term_cnt} !== {6'b100000, 4'd0}) begin
      errs++;
      $display("FAIL reset_outputs got=%b exp=%b",
               {in_rdy, acc_clr, acc_en, acc_rdy, out_vld, busy, term_cnt}, {6'b100000, 4'd0});
    end
    vecs++;
    if (vld_d !== 12'h000) begin
      errs++; $display("FAIL reset_vld_d got=%h exp=000", vld_d);
    end
    vecs++;
    if ({in_rdy1, acc_clr1, acc_en1, acc_rdy1, out_vld1, busy1, term_cnt1, vld_d1} !== {6'b100000, 1'b0, 12'h000}) begin
      errs++;
      $display("FAIL reset_k1 got=%b exp=%b",
               {in_rdy1, acc_clr1, acc_en1, acc_rdy1, out_vld1, busy1, term_cnt1, vld_d1},
               {6'b100000, 1'b0, 12'h000});
    end
    rst = 1'b0;
  endtask

  task automatic test_basic;
    do_reset();
    for (int c = 1; c <= 30; c++) begin
      in_vld = (c <= 9); out_rdy = 1'b1;
      vecs++;
      if ({in_rdy, acc_clr, acc_en, acc_rdy, out_vld, busy, term_cnt} !== {exp_basic(c), tc_basic(c)}) begin
        errs++;
        $display("FAIL basic c=%0d got=%b exp=%b", c,
                 {in_rdy, acc_clr, acc_en, acc_rdy, out_vld, busy, term_cnt}, {exp_basic(c), tc_basic(c)});
      end
      if (c == 2 || c == 3 || c == 18 || c == 29 || c == 30) begin
        logic [11:0] ev;
        ev = (c == 2) ? 12'h001 : (c == 3) ? 12'h003 : (c == 18) ? 12'hFFF :
             (c == 29) ? 12'h800 : 12'h000;
        vecs++;
        if (vld_d !== ev) begin
          errs++; $display("FAIL basic_vld_d c=%0d got=%h exp=%h", c, vld_d, ev);
        end
      end
      step();
    end
  endtask

  task automatic test_gaps;
    do_reset();
    for (int c = 1; c <= 22; c++) begin
      logic [5:0] e;
      in_vld = (c <= 11) && (c != 3) && (c != 6); out_rdy = 1'b1;
      e = {!(c >= 12 && c <= 19), c == 2, (c >= 2 && c <= 12 && c != 4 && c != 7),
           (c >= 16 && c <= 18), c == 19, (c >= 2 && c <= 19)};
      vecs++;
      if ({in_rdy, acc_clr, acc_en, acc_rdy, out_vld, busy, term_cnt} !== {e, 4'(tc_gap[c-1])}) begin
        errs++;
        $display("FAIL gaps c=%0d got=%b exp=%b", c,
                 {in_rdy, acc_clr, acc_en, acc_rdy, out_vld, busy, term_cnt}, {e, 4'(tc_gap[c-1])});
      end
      step();
    end
  endtask

  task automatic test_backpressure;
    do_reset();
    for (int c = 1; c <= 30; c++) begin
      logic [5:0] e;
      logic [3:0] et;
      // in_vld stays high into DRAIN and out_rdy pulses outside HOLD: both must be ignored
      in_vld  = (c <= 13);
      out_rdy = (c >= 10 && c <= 16) || (c >= 27);
      e  = {!(c >= 10 && c <= 27), c == 2, (c >= 2 && c <= 10),
            (c >= 14 && c <= 16), (c >= 17 && c <= 27), (c >= 2 && c <= 27)};
      et = (c >= 2 && c <= 10) ? 4'(c - 1) : (c >= 11 && c <= 27) ? 4'd9 : 4'd0;
      vecs++;
      if ({in_rdy, acc_clr, acc_en, acc_rdy, out_vld, busy, term_cnt} !== {e, et}) begin
        errs++;
        $display("FAIL backpressure c=%0d got=%b exp=%b", c,
                 {in_rdy, acc_clr, acc_en, acc_rdy, out_vld, busy, term_cnt}, {e, et});
      end
      if (c >= 2 && c <= 27) begin
        vecs++;
        if (vld_d === 12'h000) begin
          errs++; $display("FAIL backpressure_vld_d c=%0d got=%h exp=nonzero", c, vld_d);
        end
      end
      step();
    end
    out_rdy = 1'b0;
  endtask

  task automatic test_k1;
    do_reset();
    for (int c = 1; c <= 12; c++) begin
      logic [5:0] e;
      in_vld1 = (c == 1); out_rdy1 = 1'b1;
      e = {!(c >= 2 && c <= 9), c == 2, c == 2, (c >= 6 && c <= 8), c == 9, (c >= 2 && c <= 9)};
      vecs++;
      if ({in_rdy1, acc_clr1, acc_en1, acc_rdy1, out_vld1, busy1, term_cnt1} !== {e, 1'(c >= 2 && c <= 9)}) begin
        errs++;
        $display("FAIL k1 c=%0d got=%b exp=%b", c,
                 {in_rdy1, acc_clr1, acc_en1, acc_rdy1, out_vld1, busy1, term_cnt1}, {e, 1'(c >= 2 && c <= 9)});
      end
      step();
    end
    in_vld1 = 1'b0; out_rdy1 = 1'b0;
  endtask

  task automatic test_rst_mid;
    do_reset();
    for (int c = 1; c <= 31; c++) begin
      int r;
      rst = (c == 12);
      in_vld = (c <= 9) || (c >= 13 && c <= 21); out_rdy = 1'b1;
      r = (c <= 12) ? c : c - 12;
      vecs++;
      if ({in_rdy, acc_clr, acc_en, acc_rdy, out_vld, busy, term_cnt} !== {exp_basic(r), tc_basic(r)}) begin
        errs++;
        $display("FAIL rst_mid c=%0d got=%b exp=%b", c,
                 {in_rdy, acc_clr, acc_en, acc_rdy, out_vld, busy, term_cnt}, {exp_basic(r), tc_basic(r)});
      end
      if (c == 13 || c == 14) begin
        vecs++;
        if (vld_d !== ((c == 13) ? 12'h000 : 12'h001)) begin
          errs++; $display("FAIL rst_mid_vld_d c=%0d got=%h exp=%h", c, vld_d,
                           (c == 13) ? 12'h000 : 12'h001);
        end
      end
      step();
    end
    rst = 1'b0;
  endtask

`ifdef ACC_NORM_SEQ_ABORT_EN
  task automatic test_abort;
    do_reset();
    for (int c = 1; c <= 17; c++) begin
      logic [5:0] e;
      logic [3:0] et;
      in_vld = (c <= 9) || (c == 15) || (c == 16);
      abort  = (c == 15); out_rdy = 1'b1;
      e  = (c <= 15) ? exp_basic(c) : (c == 16) ? 6'b100000 : 6'b111001;
      et = (c <= 15) ? tc_basic(c) : (c == 16) ? 4'd0 : 4'd1;
      vecs++;
      if ({in_rdy, acc_clr, acc_en, acc_rdy, out_vld, busy, term_cnt} !== {e, et}) begin
        errs++;
        $display("FAIL abort c=%0d got=%b exp=%b", c,
                 {in_rdy, acc_clr, acc_en, acc_rdy, out_vld, busy, term_cnt}, {e, et});
      end
      if (c == 16) begin
        vecs++;
        if (vld_d[0] !== 1'b0) begin
          errs++; $display("FAIL abort_vld_feed got=%b exp=0", vld_d[0]);
        end
      end
      step();
    end
    abort = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_backpressure();
    test_k1();
    test_rst_mid();
`ifdef ACC_NORM_SEQ_ABORT_EN
    test_abort();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
